// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LVDS frame sequencer.
//   - default panel timing (800x480 with porches/sync widths)
//   - sequencer state enum {IDLE, RUN, STOP}
//   - lanes_t and pack_lanes(): RGB666 + DE/VS/HS -> three 7-bit FPD-Link words
//   - bar_color(): colour-bar lookup, present only when LVDS_TEST_PATTERN_EN
//     is defined
package lcd_pkg;

  localparam int DEF_H_ACTIVE     = 800;
  localparam int DEF_H_FP         = 40;
  localparam int DEF_H_SYNC       = 48;
  localparam int DEF_H_BP         = 40;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 13;
  localparam int DEF_V_SYNC       = 3;
  localparam int DEF_V_BP         = 29;
  localparam int DEF_SYNC_ACT_LOW = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] lane2;
    logic [6:0] lane1;
    logic [6:0] lane0;
  } lanes_t;

  // rgb = {R[5:0], G[5:0], B[5:0]}. Bit 6 of every lane goes out first.
  //   lane0 = {G0, R5..R0}
  //   lane1 = {B1, B0, G5..G1}
  //   lane2 = {DE, VS, HS, B5..B2}
  // hs/vs are taken at line level, so polarity is applied by the caller.
  function automatic lanes_t pack_lanes(input logic [17:0] rgb, input logic de,
                                        input logic vs, input logic hs);
    lanes_t l;
    l.lane0 = {rgb[6], rgb[17:12]};
    l.lane1 = {rgb[1:0], rgb[11:7]};
    l.lane2 = {de, vs, hs, rgb[5:2]};
    return l;
  endfunction

`ifdef LVDS_TEST_PATTERN_EN
  // Vertical colour bars, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [17:0] bar_color(input logic [2:0] idx);
    logic [17:0] c;
    case (idx)
      3'd0:    c = 18'h3FFFF;
      3'd1:    c = 18'h3FFC0;
      3'd2:    c = 18'h00FFF;
      3'd3:    c = 18'h00FC0;
      3'd4:    c = 18'h3F03F;
      3'd5:    c = 18'h3F000;
      3'd6:    c = 18'h0003F;
      default: c = 18'h00000;
    endcase
    return c;
  endfunction
`endif

endpackage

// File: rtl/lvds_frame_sequencer_if.sv
// lvds_frame_sequencer_if: pixel-fetch link between the pixel source
// (framebuffer / FWFT FIFO) and the frame sequencer.
//   pix_valid : pix_data holds a valid pixel (source -> sequencer)
//   pix_data  : {R[5:0], G[5:0], B[5:0]}     (source -> sequencer)
//   pix_rd    : pixel consumed this cycle     (sequencer -> source)
// Handshake: pix_rd is a combinational request from the sequencer. The
// source pops its head entry on a cycle where pix_rd && pix_valid. When
// pix_rd is high and pix_valid is low, no pop happens and the sequencer
// sends a black pixel instead.
// Modports: master = pixel source, slave = sequencer.
interface lvds_frame_sequencer_if;
  logic        pix_valid;
  logic [17:0] pix_data;
  logic        pix_rd;

  modport master (output pix_valid, output pix_data, input pix_rd);
  modport slave  (input pix_valid, input pix_data, output pix_rd);
endinterface

// File: rtl/lcd_timing_counter.sv
// lcd_timing_counter: horizontal/vertical panel counters and region decode.
//   clk, rst   : pixel clock, synchronous active-high reset
//   clear      : hold both counters at 0 (sequencer idle)
//   h_cnt      : 0 .. H_TOTAL-1, wraps and then bumps v_cnt
//   v_cnt      : 0 .. V_TOTAL-1
//   active     : inside the visible window
//   hs_win     : h_cnt inside the HS pulse (level-free, active-high)
//   vs_win     : v_cnt inside the VS pulse, for the whole line
//   last_pixel : last counter position of the frame
module lcd_timing_counter
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_win,
  output logic          vs_win,
  output logic          last_pixel
);

  // One extra bit on the sync end bounds: the end may equal the total,
  // which does not fit in the counter width when the total is a power of 2.
  localparam int HW1 = HW + 1;
  localparam int VW1 = VW + 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0]  HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW1-1:0] HS_END   = HW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW1-1:0] VS_END   = VW1'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_win     = (h_cnt >= HS_START) && ({1'b0, h_cnt} < HS_END);
  assign vs_win     = (v_cnt >= VS_START) && ({1'b0, v_cnt} < VS_END);
  assign last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/lvds_frame_sequencer.sv
// lvds_frame_sequencer: sequences the 3-lane LVDS (FPD-Link 7:1) panel link.
// Runs the panel timing, fetches pixels from a FWFT source and packs each
// RGB666 pixel plus DE/VS/HS into three 7-bit lane words for the serializer.
//   clk, rst    : pixel clock, synchronous active-high reset
//   en          : run request (level); dropping it finishes the current frame
//   pix         : pixel-fetch link (slave side), see lvds_frame_sequencer_if
//   pattern_en  : colour-bar select, only with LVDS_TEST_PATTERN_EN defined
//   lane0..2    : registered lane words
//   hs, vs, de  : registered copies of the lane2 control bits
//   frame_start : one-cycle pulse with the first active pixel of a frame
//   busy        : state != IDLE
//   underflow   : sticky, a pixel was due while pix_valid was low
//   state_dbg   : current FSM state
// Optional feature macro: LVDS_TEST_PATTERN_EN (adds pattern_en + colour bars).
// All registered outputs appear one cycle after the counter value they
// describe; pix_rd is combinational with the counters.
module lvds_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int SYNC_ACT_LOW = DEF_SYNC_ACT_LOW,
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW          = $clog2(H_TOTAL),
  localparam int VW          = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  lvds_frame_sequencer_if.slave  pix,
`ifdef LVDS_TEST_PATTERN_EN
  input  logic                   pattern_en,
`endif
  output logic [6:0]             lane0,
  output logic [6:0]             lane1,
  output logic [6:0]             lane2,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic                   frame_start,
  output logic                   busy,
  output logic                   underflow,
  output state_t                 state_dbg
);

  // Inactive level of HS/VS on the wire and in lane2.
  localparam logic   SYNC_OFF   = (SYNC_ACT_LOW != 0);
  localparam lanes_t LANES_IDLE = pack_lanes(18'd0, 1'b0, SYNC_OFF, SYNC_OFF);

  state_t          state, state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active, hs_win, vs_win, last_pixel;
  logic            running, fetch;
  logic [17:0]     pixel;
  logic            de_nxt, hs_nxt, vs_nxt, fs_nxt;
  lanes_t          lanes_nxt;

  lcd_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hs_win     (hs_win),
    .vs_win     (vs_win),
    .last_pixel (last_pixel)
  );

  // STOP keeps the frame going; re-raising en returns to RUN without
  // touching the counters, so the frame continues seamlessly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)              state_nxt = RUN;
        else if (last_pixel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign running = (state != IDLE);

`ifdef LVDS_TEST_PATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [HW-1:0] BAR_W_C = HW'(BAR_W);

  logic [HW-1:0] bar_q;
  logic [2:0]    bar_idx;

  // Clamp so a width not divisible by 8 widens the last (black) bar.
  assign bar_q   = h_cnt / BAR_W_C;
  assign bar_idx = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
  assign fetch   = running && active && !pattern_en;

  always_comb begin
    pixel = 18'd0;
    if (pattern_en)         pixel = bar_color(bar_idx);
    else if (pix.pix_valid) pixel = pix.pix_data;
  end
`else
  assign fetch = running && active;
  assign pixel = pix.pix_valid ? pix.pix_data : 18'd0;
`endif

  assign pix.pix_rd = fetch && !rst;

  assign de_nxt    = running && active;
  assign hs_nxt    = running && hs_win;
  assign vs_nxt    = running && vs_win;
  assign fs_nxt    = de_nxt && (h_cnt == '0) && (v_cnt == '0);
  assign lanes_nxt = pack_lanes(de_nxt ? pixel : 18'd0, de_nxt,
                                vs_nxt ^ SYNC_OFF, hs_nxt ^ SYNC_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane0       <= LANES_IDLE.lane0;
      lane1       <= LANES_IDLE.lane1;
      lane2       <= LANES_IDLE.lane2;
      hs          <= SYNC_OFF;
      vs          <= SYNC_OFF;
      de          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      lane0       <= lanes_nxt.lane0;
      lane1       <= lanes_nxt.lane1;
      lane2       <= lanes_nxt.lane2;
      hs          <= hs_nxt ^ SYNC_OFF;
      vs          <= vs_nxt ^ SYNC_OFF;
      de          <= de_nxt;
      frame_start <= fs_nxt;
      // A new run starts with a clean underflow flag.
      if ((state == IDLE) && en)      underflow <= 1'b0;
      else if (fetch && !pix.pix_valid) underflow <= 1'b1;
    end
  end

  assign busy      = running;
  assign state_dbg = state;

endmodule
